jump_physics_core: RTL

//  Per-character motion engine for the jump game: walk, charge-jump, gravity flight, ceiling/wall/floor

---
 rtl/jump_phys_pkg.sv | 48 ++++
 rtl/tick_btn_edge.sv | 24 ++
 rtl/jump_physics_core.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/jump_phys_pkg.sv
// Shared types, state encodings and fixed-point helpers for the jump physics core.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package jump_phys_pkg;

    localparam int POS_W     = 16;            // signed pos/vel width incl. fraction
    localparam int FRAC_W    = 4;             // fractional bits
    localparam int FIXED_ONE = 1 << FRAC_W;   // one pixel in fixed-point units

    typedef logic signed [POS_W-1:0] fix_t;   // architectural pos/vel value
    typedef logic signed [POS_W:0]   wide_t;  // one bit of headroom for add/sub

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WALK     = 3'd1,
        ST_CHARGE   = 3'd2,
        ST_AIRBORNE = 3'd3,
        ST_LAND     = 3'd4
    } state_t;

    localparam wide_t FIX_MAX_W = wide_t'((1 << (POS_W-1)) - 1);
    localparam wide_t FIX_MIN_W = wide_t'(-(1 << (POS_W-1)));

    // Sign-extend into the headroom width.
    function automatic wide_t widen(input fix_t v);
        return {v[POS_W-1], v};
    endfunction

    // Saturate a wide intermediate back into the architectural range.
    function automatic fix_t sat_fix(input wide_t v);
        if (v > FIX_MAX_W)
            return fix_t'(FIX_MAX_W);
        else if (v < FIX_MIN_W)
            return fix_t'(FIX_MIN_W);
        else
            return v[POS_W-1:0];
    endfunction

    function automatic fix_t clamp_fix(input fix_t v, input fix_t lo, input fix_t hi);
        if (v < lo)
            return lo;
        else if (v > hi)
            return hi;
        else
            return v;
    endfunction

endpackage

// File: rtl/tick_btn_edge.sv
// Tick-gated button history register with rising-edge detect.
// Latency: btn_rise is combinational from btn against the level sampled at the previous tick.
// Backpressure: none; history advances only on phys_tick.
// Ports: character_clk, sys_rst (sync, active-high), phys_tick, btn -> btn_rise.
module tick_btn_edge (
    input  logic character_clk,
    input  logic sys_rst,
    input  logic phys_tick,
    input  logic btn,
    output logic btn_rise
);

    logic btn_d;

    always_ff @(posedge character_clk) begin
        if (sys_rst)
            btn_d <= 1'b0;
        else if (phys_tick)
            btn_d <= btn;
    end

    assign btn_rise = btn & ~btn_d;

endmodule

// File: rtl/jump_physics_core.sv
// Per-character motion engine: walk, charge-jump, gravity flight, floor/ceiling/wall response.
// Latency: all state and outputs register on the clock edge of a phys_tick cycle; landed pulses one cycle.
// Backpressure: none; phys_tick is a frame strobe and every tick is consumed.
// Ports: character_clk, sys_rst (sync active-high), phys_tick, left_btn/right_btn/jump_btn in;
//        out_pos_x/out_pos_y (integer px), out_vel_x/out_vel_y, out_face, out_state, out_charge,
//        out_landed, out_airborne out.
// Build option: WALL_BOUNCE_EN -- wall hit reflects half of vel_x and flips facing; otherwise vel_x stops.
module jump_physics_core
    import jump_phys_pkg::*;
#(
    parameter int X_MIN        = 0,
    parameter int X_MAX        = 639,
    parameter int FLOOR_Y      = 0,
    parameter int CEIL_Y       = 479,
    parameter int CHAR_W       = 32,
    parameter int CHAR_H       = 32,
    parameter int INIT_X       = 304,
    parameter int INIT_Y       = 0,
    parameter int WALK_SPEED   = 2,
    parameter int GRAVITY      = 8,
    parameter int VY_MAX       = 256,
    parameter int MAX_CHARGE   = 31,
    parameter int JUMP_VY_BASE = 64,
    parameter int JUMP_VY_STEP = 4,
    parameter int JUMP_VX_STEP = 2
) (
    input  logic                      character_clk,
    input  logic                      sys_rst,
    input  logic                      phys_tick,
    input  logic                      left_btn,
    input  logic                      right_btn,
    input  logic                      jump_btn,
    output logic [POS_W-FRAC_W-1:0]   out_pos_x,
    output logic [POS_W-FRAC_W-1:0]   out_pos_y,
    output logic [POS_W-1:0]          out_vel_x,
    output logic [POS_W-1:0]          out_vel_y,
    output logic                      out_face,
    output logic [2:0]                out_state,
    output logic [4:0]                out_charge,
    output logic                      out_landed,
    output logic                      out_airborne
);

    // Geometry and physics constants in fixed-point units.
    localparam fix_t  X_LO    = fix_t'(X_MIN * FIXED_ONE);
    localparam fix_t  X_HI    = fix_t'((X_MAX - CHAR_W) * FIXED_ONE);
    localparam fix_t  FLOOR_U = fix_t'(FLOOR_Y * FIXED_ONE);
    localparam fix_t  CEIL_TOP= fix_t'((CEIL_Y - CHAR_H) * FIXED_ONE);
    localparam wide_t CEIL_W  = wide_t'(CEIL_Y * FIXED_ONE);
    localparam wide_t CHAR_HW = wide_t'(CHAR_H * FIXED_ONE);
    localparam wide_t WALK_W  = wide_t'(WALK_SPEED * FIXED_ONE);
    localparam wide_t GRAV_W  = wide_t'(GRAVITY);
    localparam fix_t  VY_HI   = fix_t'(VY_MAX);
    localparam fix_t  VY_LO   = fix_t'(-VY_MAX);
    localparam fix_t  ZERO    = '0;

    state_t     state;
    fix_t       pos_x, pos_y, vel_x, vel_y;
    logic       face;
    logic [4:0] charge;
    logic       landed;
    logic       airborne;
    logic       jump_rise;

    // Walk buttons are used as levels; only jump needs an edge.
    tick_btn_edge u_jump_edge (
        .character_clk (character_clk),
        .sys_rst       (sys_rst),
        .phys_tick     (phys_tick),
        .btn           (jump_btn),
        .btn_rise      (jump_rise)
    );

    fix_t walk_x, launch_vy, launch_vx_mag, launch_vx;
    fix_t vy_n, px_n, py_n, px_cl;
    logic floor_hit, ceil_hit, wall_hit;

    always_comb begin
        walk_x        = clamp_fix(sat_fix(right_btn ? widen(pos_x) + WALK_W
                                                    : widen(pos_x) - WALK_W), X_LO, X_HI);
        launch_vy     = fix_t'(JUMP_VY_BASE + int'(charge) * JUMP_VY_STEP);
        launch_vx_mag = fix_t'(int'(charge) * JUMP_VX_STEP);
        launch_vx     = face ? -launch_vx_mag : launch_vx_mag;

        // Flight step: new vertical velocity first, then position from the new velocity.
        vy_n      = clamp_fix(sat_fix(widen(vel_y) - GRAV_W), VY_LO, VY_HI);
        px_n      = sat_fix(widen(pos_x) + widen(vel_x));
        py_n      = sat_fix(widen(pos_y) + widen(vy_n));
        px_cl     = clamp_fix(px_n, X_LO, X_HI);
        floor_hit = (py_n <= FLOOR_U) && (vy_n <= ZERO);
        ceil_hit  = (widen(py_n) + CHAR_HW) > CEIL_W;
        wall_hit  = (px_n < X_LO) || (px_n > X_HI);
    end

    always_ff @(posedge character_clk) begin
        if (sys_rst) begin
            state    <= ST_IDLE;
            pos_x    <= fix_t'(INIT_X * FIXED_ONE);
            pos_y    <= fix_t'(INIT_Y * FIXED_ONE);
            vel_x    <= '0;
            vel_y    <= '0;
            face     <= 1'b0;
            charge   <= '0;
            landed   <= 1'b0;
            airborne <= 1'b0;
        end else begin
            landed <= 1'b0;
            if (phys_tick) begin
                case (state)
                    ST_IDLE, ST_WALK: begin
                        if (jump_rise) begin
                            state  <= ST_CHARGE;
                            charge <= '0;
                        end else if (left_btn ^ right_btn) begin
                            state <= ST_WALK;
                            face  <= left_btn;
                            pos_x <= walk_x;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_CHARGE: begin
                        if (jump_btn && (charge < 5'(MAX_CHARGE))) begin
                            charge <= charge + 5'd1;
                        end else begin
                            vel_y    <= launch_vy;
                            vel_x    <= launch_vx;
                            charge   <= '0;
                            state    <= ST_AIRBORNE;
                            airborne <= 1'b1;
                        end
                    end
                    ST_AIRBORNE: begin
                        pos_x <= px_cl;
                        vel_y <= vy_n;
                        if (floor_hit) begin
                            pos_y    <= FLOOR_U;
                            vel_x    <= '0;
                            vel_y    <= '0;
                            state    <= ST_LAND;
                            landed   <= 1'b1;
                            airborne <= 1'b0;
                        end else begin
                            if (ceil_hit) begin
                                pos_y <= CEIL_TOP;
                                vel_y <= '0;
                            end else begin
                                pos_y <= py_n;
                            end
                            // Landing already zeroes velocity, so wall response only matters in flight.
                            if (wall_hit) begin
`ifdef WALL_BOUNCE_EN
                                vel_x <= -(vel_x >>> 1);
                                face  <= ~face;
`else
                                vel_x <= '0;
`endif
                            end
                        end
                    end
                    ST_LAND: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign out_pos_x    = pos_x[POS_W-1:FRAC_W];
    assign out_pos_y    = pos_y[POS_W-1:FRAC_W];
    assign out_vel_x    = vel_x;
    assign out_vel_y    = vel_y;
    assign out_face     = face;
    assign out_state    = state;
    assign out_charge   = charge;
    assign out_landed   = landed;
    assign out_airborne = airborne;

endmodule
